rf_wb_arbiter: RTL and testbench

Writeback arbiter for the register file. It shares the regfile's NWRITE write ports among NREQ writeback requesters (ALU, LSU, MUL/DIV, ...) using a valid/ready handshake and a round-robin pointer. It drives the regfile write port through a registered stage and guarantees that no two ports carry the same destination in one cycle. Register-0 writes are absorbed without using a port.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/rf_wb_arbiter_rr_pick.sv | 39 +++
 rtl/rf_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and sizing helpers, used by the regfile and its
// writeback arbiter.
package regfile_pkg;

    // Address width for a given depth; never narrower than one bit.
    function automatic int aw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RF_WIDTH = 64;
    localparam int RF_NREGS = 32;
    localparam int RF_AW    = aw_of(RF_NREGS);

    typedef struct packed {
        logic [RF_AW-1:0]    addr;
        logic [RF_WIDTH-1:0] data;
    } wb_req_t;

    typedef struct packed {
        logic                we;
        logic [RF_AW-1:0]    addr;
        logic [RF_WIDTH-1:0] data;
    } rf_wport_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// Circular priority scan: one-hot grant of the first eligible requester at or
// after ptr, wrapping from N-1 back to 0.
module rr_pick
    import regfile_pkg::*;
#(
    parameter  int N  = 3,
    localparam int PW = aw_of(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] cur_s;
    logic          found_s;

    // Walk N positions from ptr; compare-and-wrap keeps non-power-of-two N legal.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        cur_s   = ptr;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                if (!found_s && elig[i] && (cur_s == PW'(i))) begin
                    grant[i] = 1'b1;
                    found_s  = 1'b1;
                end else begin
                    found_s  = found_s;
                end
            end
            if (cur_s == PW'(N - 1)) begin
                cur_s = '0;
            end else begin
                cur_s = cur_s + PW'(1);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: shares NWRITE regfile write ports among NREQ requesters
// round-robin, never issuing two enabled ports to the same destination.
module rf_wb_arbiter
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = 64,
    parameter  int NREGS    = 32,
    parameter  int NWRITE   = 1,
    parameter  int NREQ     = 3,
    parameter  int ZERO_REG = 1,
    localparam int AW       = aw_of(NREGS),
    localparam int PW       = aw_of(NREQ)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0][AW-1:0]      req_addr,
    input  logic [NREQ-1:0][WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic [NWRITE-1:0]            rf_we,
    output logic [NWRITE-1:0][AW-1:0]    rf_waddr,
    output logic [NWRITE-1:0][WIDTH-1:0] rf_wdata
);

    function automatic logic [AW-1:0] sel_addr(input logic [NREQ-1:0] oh,
                                               input logic [NREQ-1:0][AW-1:0] a);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) r = r | (a[i] & {AW{oh[i]}});
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] sel_data(input logic [NREQ-1:0] oh,
                                                  input logic [NREQ-1:0][WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) r = r | (d[i] & {WIDTH{oh[i]}});
        return r;
    endfunction

    // Requesters whose destination collides with a port already granted.
    function automatic logic [NREQ-1:0] addr_match(input logic              hit,
                                                   input logic [AW-1:0]    pa,
                                                   input logic [NREQ-1:0][AW-1:0] a);
        logic [NREQ-1:0] m;
        m = '0;
        for (int i = 0; i < NREQ; i++) m[i] = hit && (a[i] == pa);
        return m;
    endfunction

    logic [NREQ-1:0]  zero_s;
    logic [NREQ-1:0]  cand_s;
    logic [NREQ-1:0]  used_s  [NWRITE+1];
    logic [NREQ-1:0]  block_s [NWRITE+1];
    logic [NREQ-1:0]  elig_s  [NWRITE];
    logic [NREQ-1:0]  pick_s  [NWRITE];
    logic [AW-1:0]    paddr_s [NWRITE];
    logic [WIDTH-1:0] pdata_s [NWRITE];
    logic [PW-1:0]    rr_ptr_r;
    logic [PW-1:0]    rr_ptr_nxt_s;

    // Zero-destination requests are absorbed and never reach the port scan.
    always_comb begin
        zero_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            zero_s[i] = (ZERO_REG != 0) && (req_addr[i] == '0);
        end
        cand_s = req_valid & ~zero_s & {NREQ{rstn}};
    end

    assign used_s[0]  = '0;
    assign block_s[0] = '0;

    for (genvar k = 0; k < NWRITE; k++) begin : g_port
        assign elig_s[k] = cand_s & ~used_s[k] & ~block_s[k];

        rr_pick #(.N(NREQ)) u_pick (
            .elig  (elig_s[k]),
            .ptr   (rr_ptr_r),
            .grant (pick_s[k])
        );

        assign paddr_s[k]   = sel_addr(pick_s[k], req_addr);
        assign pdata_s[k]   = sel_data(pick_s[k], req_data);
        assign used_s[k+1]  = used_s[k] | pick_s[k];
        assign block_s[k+1] = block_s[k] | addr_match(|pick_s[k], paddr_s[k], req_addr);
    end

    assign req_ready = used_s[NWRITE] | (req_valid & zero_s & {NREQ{rstn}});

    // Pointer moves just past the last requester granted this cycle.
    always_comb begin
        rr_ptr_nxt_s = rr_ptr_r;
        for (int k = 0; k < NWRITE; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pick_s[k][i]) begin
                    rr_ptr_nxt_s = (i == NREQ - 1) ? '0 : PW'(i + 1);
                end else begin
                    rr_ptr_nxt_s = rr_ptr_nxt_s;
                end
            end
        end
    end

    // Round-robin pointer and registered write-port stage.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_r <= '0;
            rf_we    <= '0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rr_ptr_r <= rr_ptr_nxt_s;
            for (int k = 0; k < NWRITE; k++) begin
                rf_we[k] <= |pick_s[k];
                if (|pick_s[k]) begin
                    rf_waddr[k] <= paddr_s[k];
                    rf_wdata[k] <= pdata_s[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: one single-port and one dual-port instance
// share the same requester stimulus.
module tb_rf_wb_arbiter;

    logic              clk;
    logic              rstn;
    logic [2:0]        req_valid;
    logic [2:0][4:0]   req_addr;
    logic [2:0][63:0]  req_data;
    logic [2:0]        ready1, ready2;
    logic [0:0]        we1;
    logic [0:0][4:0]   waddr1;
    logic [0:0][63:0]  wdata1;
    logic [1:0]        we2;
    logic [1:0][4:0]   waddr2;
    logic [1:0][63:0]  wdata2;
    logic [63:0]       mem1 [32];

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_arbiter #(.WIDTH(64), .NREGS(32), .NWRITE(1), .NREQ(3), .ZERO_REG(1)) d1 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(ready1), .rf_we(we1), .rf_waddr(waddr1),
        .rf_wdata(wdata1)
    );

    rf_wb_arbiter #(.WIDTH(64), .NREGS(32), .NWRITE(2), .NREQ(3), .ZERO_REG(1)) d2 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(ready2), .rf_we(we2), .rf_waddr(waddr2),
        .rf_wdata(wdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile behind the single-port instance, cleared by the same reset.
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) mem1[i] <= 64'h0;
        end else if (we1[0]) begin
            mem1[waddr1[0]] <= wdata1[0];
        end
    end

    task automatic apply_reset();
        rstn      = 1'b0;
        req_valid = 3'b000;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        req_valid = 3'b111;
        req_addr  = '{5'd7, 5'd6, 5'd5};
        req_data  = '{64'h102, 64'h101, 64'h100};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (ready1 !== 3'b000) begin n_fail++; $display("FAIL reset_ready1 got %b want 000", ready1); end
            n_checks++;
            if (ready2 !== 3'b000) begin n_fail++; $display("FAIL reset_ready2 got %b want 000", ready2); end
            n_checks++;
            if (we1 !== 1'b0) begin n_fail++; $display("FAIL reset_we1 got %b want 0", we1); end
            n_checks++;
            if (we2 !== 2'b00) begin n_fail++; $display("FAIL reset_we2 got %b want 00", we2); end
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ready1 !== 3'b001) begin n_fail++; $display("FAIL reset_first_grant1 got %b want 001", ready1); end
        n_checks++;
        if (ready2 !== 3'b011) begin n_fail++; $display("FAIL reset_first_grant2 got %b want 011", ready2); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_r [4];
        logic [4:0] exp_a [4];
        logic [63:0] exp_d [4];
        exp_r[0] = 3'b001; exp_a[0] = 5'd5; exp_d[0] = 64'h100;
        exp_r[1] = 3'b010; exp_a[1] = 5'd6; exp_d[1] = 64'h101;
        exp_r[2] = 3'b100; exp_a[2] = 5'd7; exp_d[2] = 64'h102;
        exp_r[3] = 3'b001; exp_a[3] = 5'd5; exp_d[3] = 64'h100;
        apply_reset();
        req_addr  = '{5'd7, 5'd6, 5'd5};
        req_data  = '{64'h102, 64'h101, 64'h100};
        req_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (ready1 !== exp_r[c]) begin n_fail++; $display("FAIL rr_ready[%0d] got %b want %b", c, ready1, exp_r[c]); end
            @(posedge clk); #1;
            n_checks++;
            if (we1 !== 1'b1 || waddr1[0] !== exp_a[c] || wdata1[0] !== exp_d[c]) begin
                n_fail++;
                $display("FAIL rr_port[%0d] got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                         c, we1, waddr1[0], wdata1[0], exp_a[c], exp_d[c]);
            end
        end
        req_valid = 3'b000;
    endtask

    task automatic test_conflict();
        apply_reset();
        req_addr  = '{5'd4, 5'd9, 5'd9};
        req_data  = '{64'h33, 64'h22, 64'h11};
        req_valid = 3'b111;
        @(negedge clk);
        n_checks++;
        if (ready2 !== 3'b101) begin n_fail++; $display("FAIL conf_ready_c1 got %b want 101", ready2); end
        @(posedge clk); #1;
        n_checks++;
        if (we2 !== 2'b11 || waddr2[0] !== 5'd9 || waddr2[1] !== 5'd4 || wdata2[0] !== 64'h11 || wdata2[1] !== 64'h33) begin
            n_fail++;
            $display("FAIL conf_ports_c1 got we=%b a0=%0d a1=%0d d0=%h d1=%h want we=11 a0=9 a1=4 d0=11 d1=33",
                     we2, waddr2[0], waddr2[1], wdata2[0], wdata2[1]);
        end
        req_valid = 3'b010;
        @(negedge clk);
        n_checks++;
        if (ready2 !== 3'b010) begin n_fail++; $display("FAIL conf_ready_c2 got %b want 010", ready2); end
        @(posedge clk); #1;
        n_checks++;
        if (we2 !== 2'b01 || waddr2[0] !== 5'd9 || wdata2[0] !== 64'h22) begin
            n_fail++;
            $display("FAIL conf_ports_c2 got we=%b a0=%0d d0=%h want we=01 a0=9 d0=22", we2, waddr2[0], wdata2[0]);
        end
        req_valid = 3'b000;
        @(posedge clk); #1;
        n_checks++;
        if (we2 !== 2'b00 || waddr2[0] !== 5'd9 || waddr2[1] !== 5'd4) begin
            n_fail++;
            $display("FAIL conf_idle_hold got we=%b a0=%0d a1=%0d want we=00 a0=9 a1=4", we2, waddr2[0], waddr2[1]);
        end
    endtask

    task automatic test_zero_drop();
        apply_reset();
        req_addr  = '{5'd7, 5'd0, 5'd3};
        req_data  = '{64'h77, 64'hDEAD, 64'h33};
        req_valid = 3'b011;
        @(negedge clk);
        n_checks++;
        if (ready1 !== 3'b011) begin n_fail++; $display("FAIL zero_ready got %b want 011", ready1); end
        @(posedge clk); #1;
        n_checks++;
        if (we1 !== 1'b1 || waddr1[0] !== 5'd3 || wdata1[0] !== 64'h33) begin
            n_fail++;
            $display("FAIL zero_port got we=%b addr=%0d data=%h want we=1 addr=3 data=33", we1, waddr1[0], wdata1[0]);
        end
        req_addr  = '{5'd7, 5'd6, 5'd3};
        req_valid = 3'b111;
        @(negedge clk);
        n_checks++;
        if (ready1 !== 3'b010) begin n_fail++; $display("FAIL zero_ptr_next got %b want 010", ready1); end
        req_valid = 3'b000;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        req_addr  = '{5'd12, 5'd1, 5'd1};
        req_data  = '{64'h55, 64'h0, 64'h0};
        req_valid = 3'b100;
        @(negedge clk);
        n_checks++;
        if (ready1 !== 3'b100) begin n_fail++; $display("FAIL mid_ready got %b want 100", ready1); end
        @(posedge clk); #1;
        n_checks++;
        if (we1 !== 1'b1 || waddr1[0] !== 5'd12) begin
            n_fail++;
            $display("FAIL mid_inflight got we=%b addr=%0d want we=1 addr=12", we1, waddr1[0]);
        end
        rstn      = 1'b0;
        req_valid = 3'b000;
        @(posedge clk); #1;
        n_checks++;
        if (we1 !== 1'b0 || waddr1[0] !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_discard got we=%b addr=%0d want we=0 addr=0", we1, waddr1[0]);
        end
        n_checks++;
        if (mem1[12] !== 64'h0) begin n_fail++; $display("FAIL mid_rf_x12 got %h want 0", mem1[12]); end
        rstn = 1'b1;
    endtask

    task automatic test_hold_stability();
        int beef_writes;
        beef_writes = 0;
        apply_reset();
        req_addr  = '{5'd4, 5'd9, 5'd9};
        req_data  = '{64'h44, 64'hBEEF, 64'hA0};
        req_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            req_data[0] = 64'hA0 + 64'(c);
            @(negedge clk);
            n_checks++;
            if (ready2 !== 3'b101) begin n_fail++; $display("FAIL hold_stall[%0d] got %b want 101", c, ready2); end
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) if (we2[k] && wdata2[k] == 64'hBEEF) beef_writes++;
        end
        req_valid = 3'b010;
        @(negedge clk);
        n_checks++;
        if (ready2 !== 3'b010) begin n_fail++; $display("FAIL hold_grant got %b want 010", ready2); end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) if (we2[k] && wdata2[k] == 64'hBEEF) beef_writes++;
        n_checks++;
        if (we2 !== 2'b01 || waddr2[0] !== 5'd9 || wdata2[0] !== 64'hBEEF) begin
            n_fail++;
            $display("FAIL hold_port got we=%b a0=%0d d0=%h want we=01 a0=9 d0=beef", we2, waddr2[0], wdata2[0]);
        end
        req_valid = 3'b000;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) if (we2[k] && wdata2[k] == 64'hBEEF) beef_writes++;
        n_checks++;
        if (beef_writes !== 1) begin n_fail++; $display("FAIL hold_once got %0d writes want 1", beef_writes); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn      = 1'b0;
        req_valid = 3'b000;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_round_robin();
        test_conflict();
        test_zero_drop();
        test_reset_midflight();
        test_hold_stability();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
